// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch front end issuing in-order requests and presenting predecoded bundles to decode.
// Define IF_FETCHQ_BYPASS_EN to forward a response straight to decode when the queue is empty.
module if_fetch_queue #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        req_valid,
    output logic [31:0] req_addr,
    input  logic        req_ready,
    input  logic        rsp_valid,
    input  logic [31:0] rsp_data,
    input  logic        bp_taken,
    input  logic [31:0] bp_target,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        id_stall,
    output logic        id_valid,
    output logic [31:0] id_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc4,
    output logic [31:0] id_predict_pc,
    output logic        id_is_conditional_branch,
    output logic        id_is_jalr,
    output logic        id_is_jal,
    output logic        id_predict_taken
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef struct packed {
        logic [31:0] pc;
        logic        taken;
        logic [31:0] target;
    } meta_t;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] predict_pc;
        logic        cond;
        logic        jalr;
        logic        jal;
        logic        taken;
    } entry_t;

    logic [31:0]   pc;
    logic [CW-1:0] outstanding;
    logic [CW-1:0] drop;
    logic [CW-1:0] count;
    logic [CW:0]   credit_used;
    meta_t         meta_mem [DEPTH];
    entry_t        q_mem [DEPTH];
    logic [AW-1:0] meta_wr;
    logic [AW-1:0] meta_rd;
    logic [AW-1:0] q_wr;
    logic [AW-1:0] q_rd;
    logic          accept;
    logic          rsp_live;
    logic          byp;
    logic          push_q;
    logic          pop_q;
    entry_t        rsp_entry;
    entry_t        head;
    entry_t        out;
    entry_t        sel;

    function automatic entry_t build(input meta_t m, input logic [31:0] inst);
        entry_t e;
        e.inst       = inst;
        e.pc         = m.pc;
        e.pc4        = m.pc + 32'd4;
        e.predict_pc = m.target;
        e.taken      = m.taken;
        e.cond       = inst[6:0] == 7'b1100011;
        e.jalr       = inst[6:0] == 7'b1100111;
        e.jal        = inst[6:0] == 7'b1101111;
        return e;
    endfunction

    always_comb begin
        credit_used = {1'b0, outstanding} + {1'b0, count};
        req_valid   = !rst && !redirect_valid && credit_used < (CW+1)'(DEPTH) && drop == '0;
        req_addr    = pc;
        accept      = req_valid && req_ready;
        rsp_live    = rsp_valid && drop == '0;
        rsp_entry   = build(meta_mem[meta_rd], rsp_data);
        head        = q_mem[q_rd];
`ifdef IF_FETCHQ_BYPASS_EN
        byp         = count == '0 && !redirect_valid && rsp_live;
        out         = byp ? rsp_entry : head;
`else
        byp         = 1'b0;
        out         = head;
`endif
        id_valid    = count != '0 || byp;
        sel         = id_valid ? out : '0;
        pop_q       = count != '0 && !id_stall;
        // a bypassed word consumed by decode this cycle never occupies a slot
        push_q      = rsp_live && !(byp && !id_stall);
    end

    assign id_inst                  = sel.inst;
    assign id_pc                    = sel.pc;
    assign id_pc4                   = sel.pc4;
    assign id_predict_pc            = sel.predict_pc;
    assign id_is_conditional_branch = sel.cond;
    assign id_is_jalr               = sel.jalr;
    assign id_is_jal                = sel.jal;
    assign id_predict_taken         = sel.taken;

    always_ff @(posedge clk) begin
        if (!rst && !redirect_valid && accept)
            meta_mem[meta_wr] <= '{pc: pc, taken: bp_taken, target: bp_target};
        if (!rst && !redirect_valid && push_q)
            q_mem[q_wr] <= rsp_entry;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            outstanding <= '0;
            drop        <= '0;
            count       <= '0;
            meta_wr     <= '0;
            meta_rd     <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else if (redirect_valid) begin
            // every response still in flight belongs to the squashed path
            pc          <= redirect_pc;
            drop        <= outstanding - CW'(rsp_valid && outstanding != '0);
            outstanding <= outstanding - CW'(rsp_valid && outstanding != '0);
            count       <= '0;
            meta_wr     <= '0;
            meta_rd     <= '0;
            q_wr        <= '0;
            q_rd        <= '0;
        end else begin
            if (accept) begin
                pc      <= bp_taken ? bp_target : pc + 32'd4;
                meta_wr <= meta_wr + AW'(1);
            end
            if (rsp_valid && drop != '0)
                drop <= drop - CW'(1);
            if (rsp_live)
                meta_rd <= meta_rd + AW'(1);
            if (push_q)
                q_wr <= q_wr + AW'(1);
            if (pop_q)
                q_rd <= q_rd + AW'(1);
            count       <= count + CW'(push_q) - CW'(pop_q);
            outstanding <= outstanding + CW'(accept) - CW'(rsp_valid);
        end
    end
endmodule

// File: tb/tb_if_fetch_queue.sv
// tb_if_fetch_queue: directed and randomized checks of if_fetch_queue against a request-level model
// with an in-order latency memory and a table-driven branch predictor.
module tb_if_fetch_queue;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
`ifdef IF_FETCHQ_BYPASS_EN
    localparam int DEC_LAT = 1;
`else
    localparam int DEC_LAT = 2;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid, req_ready = 1'b0;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = '0;
    logic        bp_taken = 1'b0;
    logic [31:0] bp_target = '0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        id_stall = 1'b0;
    logic        id_valid;
    logic [31:0] id_inst, id_pc, id_pc4, id_predict_pc;
    logic        id_is_conditional_branch, id_is_jalr, id_is_jal, id_predict_taken;

    always #5 clk = ~clk;

    if_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .bp_taken(bp_taken), .bp_target(bp_target),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .id_stall(id_stall), .id_valid(id_valid),
        .id_inst(id_inst), .id_pc(id_pc), .id_pc4(id_pc4), .id_predict_pc(id_predict_pc),
        .id_is_conditional_branch(id_is_conditional_branch), .id_is_jalr(id_is_jalr),
        .id_is_jal(id_is_jal), .id_predict_taken(id_predict_taken)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        arrived;
    } live_t;

    typedef struct {
        logic [31:0] addr;
        int          due;
        logic        stale;
    } pend_t;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ppc;
        logic        pt;
        logic        cond;
        logic        jalr;
        logic        jal;
        int          cyc;
    } dec_t;

    live_t       live[$];
    pend_t       pend[$];
    dec_t        obs_dec[$];
    logic [31:0] obs_req[$];
    int          obs_req_cyc[$];
    logic [31:0] imem[logic [31:0]];
    logic [31:0] bp_tab[logic [31:0]];
    logic [31:0] model_pc = RESET_PC;
    int          cyc = 0;
    int          lat = 1;
    int          jit = 0;
    int          last_due = 0;
    int          model_err = 0;
    string       model_msg = "";
    int          tests = 0;
    int          fails = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] h;
        logic [6:0]  op;
        if (imem.exists(a)) return imem[a];
        h  = (a * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        op = h[2:0] == 3'd0 ? 7'b1100011 : h[2:0] == 3'd1 ? 7'b1100111 :
             h[2:0] == 3'd2 ? 7'b1101111 : 7'b0010011;
        return {h[31:7], op};
    endfunction

    function automatic void note(input string s);
        if (model_err == 0) model_msg = s;
        model_err++;
    endfunction

    function automatic logic [31:0] req_n(input int i);
        if (i < obs_req.size()) return obs_req[i];
        return 32'hDEAD_BEEF;
    endfunction

    function automatic int req_cyc_n(input int i);
        if (i < obs_req_cyc.size()) return obs_req_cyc[i];
        return -1;
    endfunction

    function automatic dec_t dec_n(input int i);
        dec_t d;
        if (i < obs_dec.size()) return obs_dec[i];
        d = '{32'h0, 32'hDEAD_BEEF, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, -1};
        return d;
    endfunction

    // One clock of memory + predictor + reference model; mismatches are tallied in model_err.
    task automatic step();
        logic        resp, exp_rv, exp_idv, byp, cons, acc, done;
        int          arr, stl, dd;
        logic [31:0] w;
        live_t       e;
        pend_t       p;
        dec_t        d;
        resp = 1'b0;
        if (pend.size() > 0) resp = pend[0].due <= cyc;
        rsp_valid = resp;
        rsp_data  = $urandom;
        if (resp) rsp_data = mem_word(pend[0].addr);
        bp_taken  = bp_tab.exists(req_addr);
        bp_target = $urandom;
        if (bp_taken) bp_target = bp_tab[req_addr];
        @(negedge clk);
        arr = 0;
        foreach (live[i]) if (live[i].arrived) arr++;
        stl = 0;
        foreach (pend[i]) if (pend[i].stale) stl++;
        exp_rv = !rst && !redirect_valid && (pend.size() + arr < DEPTH) && stl == 0;
        if (req_valid !== exp_rv) note($sformatf("cyc %0d req_valid %b want %b", cyc, req_valid, exp_rv));
        acc = req_valid === 1'b1 && req_ready && !rst;
        if (acc) begin
            obs_req.push_back(req_addr);
            obs_req_cyc.push_back(cyc);
            if (req_addr !== model_pc) note($sformatf("cyc %0d req_addr %h want %h", cyc, req_addr, model_pc));
        end
        byp = 1'b0;
`ifdef IF_FETCHQ_BYPASS_EN
        if (resp && !redirect_valid && arr == 0) byp = !pend[0].stale;
`endif
        exp_idv = arr > 0 || byp;
        cons = 1'b0;
        if (!rst) begin
            if (id_valid !== exp_idv)
                note($sformatf("cyc %0d id_valid %b want %b", cyc, id_valid, exp_idv));
            else if (exp_idv && live.size() == 0)
                note($sformatf("cyc %0d model has no entry to present", cyc));
            else if (exp_idv) begin
                e = live[0];
                w = mem_word(e.pc);
                if ({id_inst, id_pc, id_pc4, id_predict_pc, id_predict_taken,
                     id_is_conditional_branch, id_is_jalr, id_is_jal} !==
                    {w, e.pc, e.pc + 32'd4, e.target, e.taken,
                     w[6:0] == 7'b1100011, w[6:0] == 7'b1100111, w[6:0] == 7'b1101111})
                    note($sformatf("cyc %0d entry pc %h inst %h want pc %h inst %h", cyc, id_pc, id_inst, e.pc, w));
                cons = !id_stall && !redirect_valid;
            end
        end
        if (cons) begin
            d = '{id_inst, id_pc, id_pc4, id_predict_pc, id_predict_taken,
                  id_is_conditional_branch, id_is_jalr, id_is_jal, cyc};
            obs_dec.push_back(d);
        end
        if (rst) begin
            live.delete();
            pend.delete();
            model_pc = RESET_PC;
        end else if (redirect_valid) begin
            foreach (pend[i]) pend[i].stale = 1'b1;
            if (resp) void'(pend.pop_front());
            live.delete();
            model_pc = redirect_pc;
        end else begin
            if (resp) begin
                p = pend.pop_front();
                done = 1'b0;
                if (!p.stale)
                    foreach (live[i])
                        if (!done && !live[i].arrived) begin
                            live[i].arrived = 1'b1;
                            done = 1'b1;
                        end
            end
            if (cons) void'(live.pop_front());
            if (acc) begin
                e = '{model_pc, bp_target, bp_taken, 1'b0};
                live.push_back(e);
                dd = cyc + lat + (jit > 0 ? int'($urandom_range(jit, 0)) : 0);
                if (dd < last_due) dd = last_due;
                last_due = dd;
                p = '{req_addr, dd, 1'b0};
                pend.push_back(p);
                model_pc = bp_taken ? bp_target : model_pc + 32'd4;
            end
        end
        arr = 0;
        foreach (live[i]) if (live[i].arrived) arr++;
        if (pend.size() + arr > DEPTH) note($sformatf("cyc %0d queue overflow: %0d in use", cyc, pend.size() + arr));
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        req_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        obs_req.delete();
        obs_req_cyc.delete();
        obs_dec.delete();
        model_err = 0;
        jit = 0;
    endtask

    task automatic test_reset();
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        tests++;
        if (req_valid !== 1'b0) begin fails++; $display("FAIL reset_req_valid: got %b want 0", req_valid); end
        tests++;
        if (req_addr !== RESET_PC) begin fails++; $display("FAIL reset_req_addr: got %h want %h", req_addr, RESET_PC); end
        tests++;
        if (id_valid !== 1'b0) begin fails++; $display("FAIL reset_id_valid: got %b want 0", id_valid); end
        tests++;
        if ({id_inst, id_pc, id_pc4, id_predict_pc, id_predict_taken, id_is_conditional_branch, id_is_jalr, id_is_jal} !== '0) begin
            fails++;
            $display("FAIL reset_id_fields: got inst %h pc %h pc4 %h ppc %h want all 0", id_inst, id_pc, id_pc4, id_predict_pc);
        end
        rst = 1'b0;
        req_ready = 1'b1;
        step();
        tests++;
        if (req_n(0) !== RESET_PC) begin fails++; $display("FAIL first_request: got %h want %h", req_n(0), RESET_PC); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL reset_model: %0d errors (want 0), first: %s", model_err, model_msg); end
    endtask

    task automatic test_sequential();
        dec_t d;
        lat = 1;
        do_reset();
        req_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 3; i++) begin
            tests++;
            if (req_n(i) !== 32'(4 * i)) begin fails++; $display("FAIL seq_req%0d: got %h want %h", i, req_n(i), 32'(4 * i)); end
            d = dec_n(i);
            tests++;
            if (d.pc !== 32'(4 * i) || d.pc4 !== 32'(4 * i + 4))
                begin fails++; $display("FAIL seq_dec%0d: got pc %h pc4 %h want %h %h", i, d.pc, d.pc4, 32'(4 * i), 32'(4 * i + 4)); end
        end
        tests++;
        if (req_cyc_n(2) - req_cyc_n(0) !== 2) begin fails++; $display("FAIL seq_back_to_back: got spacing %0d want 2", req_cyc_n(2) - req_cyc_n(0)); end
        d = dec_n(0);
        tests++;
        if (d.cyc - req_cyc_n(0) !== DEC_LAT) begin fails++; $display("FAIL seq_latency: got %0d want %0d", d.cyc - req_cyc_n(0), DEC_LAT); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL seq_model: %0d errors (want 0), first: %s", model_err, model_msg); end
    endtask

    task automatic test_predecode();
        logic [2:0] want [4];
        dec_t d;
        want = '{3'b100, 3'b010, 3'b001, 3'b000};
        imem[32'h0] = 32'h0000_0463;
        imem[32'h4] = 32'h0000_00E7;
        imem[32'h8] = 32'h0000_006F;
        imem[32'hC] = 32'h0000_0013;
        lat = 1;
        do_reset();
        req_ready = 1'b1;
        repeat (12) step();
        for (int i = 0; i < 4; i++) begin
            d = dec_n(i);
            tests++;
            if ({d.cond, d.jalr, d.jal} !== want[i] || d.pc !== 32'(4 * i))
                begin fails++; $display("FAIL predecode%0d: got pc %h flags %b want pc %h flags %b", i, d.pc, {d.cond, d.jalr, d.jal}, 32'(4 * i), want[i]); end
        end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL predecode_model: %0d errors (want 0), first: %s", model_err, model_msg); end
        imem.delete();
    endtask

    task automatic test_predict();
        dec_t d;
        bp_tab[32'h8] = 32'h100;
        lat = 1;
        do_reset();
        req_ready = 1'b1;
        repeat (10) step();
        tests++;
        if (req_n(3) !== 32'h100) begin fails++; $display("FAIL predict_req: got %h want 00000100", req_n(3)); end
        d = dec_n(2);
        tests++;
        if (d.pc !== 32'h8 || d.pt !== 1'b1 || d.ppc !== 32'h100)
            begin fails++; $display("FAIL predict_meta: got pc %h taken %b target %h want 8 1 100", d.pc, d.pt, d.ppc); end
        d = dec_n(3);
        tests++;
        if (d.pc !== 32'h100 || d.pt !== 1'b0) begin fails++; $display("FAIL predict_next: got pc %h taken %b want 100 0", d.pc, d.pt); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL predict_model: %0d errors (want 0), first: %s", model_err, model_msg); end
        bp_tab.delete();
    endtask

    task automatic test_stall();
        dec_t d;
        int   bad;
        lat = 1;
        do_reset();
        req_ready = 1'b1;
        id_stall = 1'b1;
        repeat (10) step();
        tests++;
        if (obs_req.size() !== DEPTH) begin fails++; $display("FAIL stall_credit: got %0d requests want %0d", obs_req.size(), DEPTH); end
        tests++;
        if (req_valid !== 1'b0 || id_valid !== 1'b1 || id_pc !== 32'h0)
            begin fails++; $display("FAIL stall_hold: got req_valid %b id_valid %b id_pc %h want 0 1 0", req_valid, id_valid, id_pc); end
        id_stall = 1'b0;
        repeat (12) step();
        for (int i = 0; i < 4; i++) begin
            d = dec_n(i);
            tests++;
            if (d.pc !== 32'(4 * i)) begin fails++; $display("FAIL stall_drain%0d: got %h want %h", i, d.pc, 32'(4 * i)); end
        end
        bad = -1;
        foreach (obs_dec[i]) if (bad < 0 && obs_dec[i].pc !== 32'(4 * i)) bad = i;
        tests++;
        if (bad !== -1) begin fails++; $display("FAIL stall_order: got first bad index %0d want none", bad); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL stall_model: %0d errors (want 0), first: %s", model_err, model_msg); end
    endtask

    task automatic test_redirect();
        dec_t d;
        int   rc;
        lat = 3;
        do_reset();
        req_ready = 1'b1;
        step();
        step();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        rc = cyc;
        step();
        redirect_valid = 1'b0;
        tests++;
        if (req_addr !== 32'h200 || id_valid !== 1'b0)
            begin fails++; $display("FAIL redirect_next: got req_addr %h id_valid %b want 200 0", req_addr, id_valid); end
        req_ready = 1'b1;
        repeat (12) step();
        tests++;
        if (req_n(2) !== 32'h200 || req_cyc_n(2) - rc !== 3)
            begin fails++; $display("FAIL redirect_drop: got %h after %0d cycles want 200 after 3", req_n(2), req_cyc_n(2) - rc); end
        d = dec_n(0);
        tests++;
        if (d.pc !== 32'h200) begin fails++; $display("FAIL redirect_first_dec: got %h want 00000200", d.pc); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL redirect_model: %0d errors (want 0), first: %s", model_err, model_msg); end
    endtask

    task automatic test_redirect_same_cycle();
        dec_t d;
        int   rc;
        lat = 1;
        do_reset();
        req_ready = 1'b1;
        step();
        req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc = 32'h200;
        rc = cyc;
        step();
        redirect_valid = 1'b0;
        req_ready = 1'b1;
        step();
        tests++;
        if (req_n(1) !== 32'h200 || req_cyc_n(1) !== rc + 1)
            begin fails++; $display("FAIL same_cycle_issue: got %h at +%0d want 200 at +1", req_n(1), req_cyc_n(1) - rc); end
        repeat (6) step();
        d = dec_n(0);
        tests++;
        if (d.pc !== 32'h200) begin fails++; $display("FAIL same_cycle_first_dec: got %h want 00000200", d.pc); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL same_cycle_model: %0d errors (want 0), first: %s", model_err, model_msg); end
    endtask

    task automatic test_random();
        int n;
        lat = 2;
        do_reset();
        jit = 2;
        repeat (12) bp_tab[32'($urandom_range(0, 255)) << 2] = 32'($urandom_range(0, 255)) << 2;
        repeat (1500) begin
            rst = $urandom_range(0, 499) == 0;
            req_ready = $urandom_range(0, 3) != 0;
            id_stall = $urandom_range(0, 3) == 0;
            redirect_valid = $urandom_range(0, 39) == 0;
            redirect_pc = 32'($urandom_range(0, 255)) << 2;
            if ($urandom_range(0, 299) == 0) lat = $urandom_range(1, 4);
            step();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        id_stall = 1'b0;
        req_ready = 1'b0;
        n = 0;
        while (live.size() > 0 && n < 60) begin
            step();
            n++;
        end
        tests++;
        if (live.size() !== 0) begin fails++; $display("FAIL random_drain: got %0d entries left want 0", live.size()); end
        tests++;
        if (obs_dec.size() < 200) begin fails++; $display("FAIL random_progress: got %0d decoded want at least 200", obs_dec.size()); end
        tests++;
        if (model_err !== 0) begin fails++; $display("FAIL random_model: %0d errors (want 0), first: %s", model_err, model_msg); end
        bp_tab.delete();
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_predecode();
        test_predict();
        test_stall();
        test_redirect();
        test_redirect_same_cycle();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule
